// File: rtl/alu_operand_sequencer_pkg.sv
// rtl/alu_operand_sequencer_pkg.sv - sequencer state encoding and board ALU opcode constants
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - operand/result bus between the sequencer and the board ALU
interface alu_operand_sequencer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;

  // Sequencer side: drives operands and opcode, receives the ALU answer
  modport master (
    output alu_a, alu_b, alu_sel, alu_valid,
    input  alu_result, alu_carry
  );

  // ALU side
  modport slave (
    input  alu_a, alu_b, alu_sel, alu_valid,
    output alu_result, alu_carry
  );

endinterface

// File: rtl/alu_operand_sequencer_btn_sync_edge.sv
// rtl/alu_operand_sequencer_btn_sync_edge.sv - button synchroniser and edge pulse, debounce under ALU_SEQ_DEBOUNCE_EN
module btn_sync_edge #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic s1;
  logic s2;

  // A debounce window of zero cycles has no meaning
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_sync_edge: DEBOUNCE_CYCLES must be at least 1");
  end

  // Two-flop synchroniser for the raw board button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign level = s2;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          db;
  logic          db_q;

  // Accept a new level only after it has differed from btn_db for the full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
    end else begin
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = db & ~db_q;
`else
  logic s3;

  // Delayed copy of the synchronised level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3 <= 1'b0;
    end else begin
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;
`endif

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - captures A, B and opcode for the board ALU and registers its result; ALU_SEQ_DEBOUNCE_EN adds button debounce
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        sw,
  input  logic                    btn_next,
  input  logic                    btn_clear,
  alu_operand_sequencer_if.master bus,
  output logic [WIDTH-1:0]        result_q,
  output logic                    zero_q,
  output logic                    carry_q,
  output logic [2:0]              state_o
);

  seq_state_t       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       sel_q;
  logic             valid_q;
  logic             next_level;
  logic             next_p;
  logic             clr_s1;
  logic             clr_s2;

  btn_sync_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .level (next_level),
    .pulse (next_p)
  );

  // Clear is level-sensitive and deliberately not debounced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      clr_s1 <= btn_clear;
      clr_s2 <= clr_s1;
    end
  end

  // Sequencer FSM: one capture per press, one-cycle EXEC latches the ALU answer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else if (clr_s2) begin
      state    <= LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (next_p) begin
          a_q   <= sw;
          state <= LOAD_B;
        end
        LOAD_B: if (next_p) begin
          b_q   <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: if (next_p) begin
          sel_q   <= sw[3:0];
          valid_q <= 1'b1;
          state   <= EXEC;
        end
        EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= (bus.alu_result == '0);
          carry_q  <= bus.alu_carry;
          state    <= SHOW;
        end
        SHOW: if (next_p) begin
          valid_q <= 1'b0;
          state   <= LOAD_A;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= LOAD_A;
        end
      endcase
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.alu_valid = valid_q;
  assign state_o       = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - randomized scoreboard bench for alu_operand_sequencer
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int HOLD = 10;
  localparam int GAP  = 10;
  localparam int LAT  = 6;
`else
  localparam int HOLD = 3;
  localparam int GAP  = 3;
  localparam int LAT  = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       btn_next = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] result_q;
  logic       zero_q;
  logic       carry_q;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] r;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.WIDTH(4)) bus ();

  alu_operand_sequencer #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .bus       (bus),
    .result_q  (result_q),
    .zero_q    (zero_q),
    .carry_q   (carry_q),
    .state_o   (state_o)
  );

  // Stand-in for the board ALU: carry always comes from the A+B adder
  logic [4:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  always_comb begin
    bus.alu_carry  = alu_sum[4];
    bus.alu_result = 4'h0;
    case (bus.alu_sel)
      OP_ADD: bus.alu_result = alu_sum[3:0];
      OP_SHL: bus.alu_result = {bus.alu_a[2:0], 1'b0};
      OP_SHR: bus.alu_result = {1'b0, bus.alu_a[3:1]};
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = 4'h0;
    endcase
  end

  // Reference: what the display should show for operands a, b and opcode op
  function automatic exp_t ref_op(input int a, input int b, input logic [3:0] op);
    exp_t e;
    int   r;
    case (op)
      OP_ADD:  r = (a + b) % 16;
      OP_SHL:  r = (a * 2) % 16;
      OP_SHR:  r = a / 2;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = 0;
    endcase
    e.r = 4'(r);
    e.z = (r == 0);
    e.c = (a + b) > 15;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every EXEC->SHOW transition presents a result to be scored
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    if (rst_n && prev_state == 3'd3 && state_o == 3'd4) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: result %0d shown, no expected entry", result_q);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", int'(result_q), int'(e.r));
        check("sb_zero", int'(zero_q), int'(e.z));
        check("sb_carry", int'(carry_q), int'(e.c));
        check("sb_valid", int'(bus.alu_valid), 1);
      end
    end
    prev_state = state_o;
  end

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_next = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state_o !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state_o), int'(s));
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    exp_q.push_back(ref_op(int'(a), int'(b), op));
    press(a);
    press(b);
    press(op);
    wait_state(3'd4, "reach_show");
    check("alu_a", int'(bus.alu_a), int'(a));
    check("alu_b", int'(bus.alu_b), int'(b));
    check("alu_sel", int'(bus.alu_sel), int'(op));
    press(4'h0);
    wait_state(3'd0, "show_to_load_a");
  endtask

  logic [3:0] ops [6] = '{OP_ADD, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state_o), 0);
    check("rst_alu_a", int'(bus.alu_a), 0);
    check("rst_alu_b", int'(bus.alu_b), 0);
    check("rst_alu_sel", int'(bus.alu_sel), 0);
    check("rst_valid", int'(bus.alu_valid), 0);
    check("rst_result", int'(result_q), 0);
    check("rst_zero", int'(zero_q), 0);
    check("rst_carry", int'(carry_q), 0);
    rst_n = 1'b1;

    // 9 + 8 with ADD; the first press also measures latency and is held 20 cycles
    exp_q.push_back(ref_op(9, 8, OP_ADD));
    @(negedge clk);
    sw = 4'd9;
    btn_next = 1'b1;
    repeat (LAT) @(negedge clk);
    check("latency_before", int'(state_o), 0);
    @(negedge clk);
    check("latency_after", int'(state_o), 1);
    check("latency_alu_a", int'(bus.alu_a), 9);
    repeat (20 - LAT - 1) @(negedge clk);
    btn_next = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("held_one_advance", int'(state_o), 1);
    press(4'd8);
    press(OP_ADD);
    wait_state(3'd4, "add_show");
    check("add_valid", int'(bus.alu_valid), 1);
    check("add_result", int'(result_q), 1);
    check("add_carry", int'(carry_q), 1);
    press(4'h0);
    wait_state(3'd0, "add_back");
    check("load_a_valid", int'(bus.alu_valid), 0);

    run_op(4'd5, 4'd3, OP_XOR);
    run_op(4'd5, 4'd5, OP_XOR);

    repeat (6) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ops[$urandom_range(0, 5)]);
    end

    // A next pulse landing in EXEC must not skip SHOW
    exp_q.push_back(ref_op(2, 3, OP_ADD));
    press(4'd2);
    press(4'd3);
    @(negedge clk);
    sw = OP_ADD;
    btn_next = 1'b1;
    wait_state(3'd3, "reach_exec");
    force dut.next_p = 1'b1;
    @(posedge clk);
    #1;
    release dut.next_p;
    @(negedge clk);
    check("exec_ignores_next", int'(state_o), 4);
    btn_next = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("show_holds", int'(state_o), 4);
    press(4'h0);
    wait_state(3'd0, "exec_test_back");

    // Clear and next together in LOAD_OP: clear wins
    press(4'd7);
    press(4'd2);
    check("clr_in_load_op", int'(state_o), 2);
    @(negedge clk);
    sw = OP_ADD;
    btn_next = 1'b1;
    btn_clear = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_next = 1'b0;
    btn_clear = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("clr_state", int'(state_o), 0);
    check("clr_alu_a", int'(bus.alu_a), 0);
    check("clr_alu_b", int'(bus.alu_b), 0);
    check("clr_alu_sel", int'(bus.alu_sel), 0);
    check("clr_result", int'(result_q), 0);
    check("clr_valid", int'(bus.alu_valid), 0);

    // Asynchronous reset in LOAD_B with a non-zero result on display
    run_op(4'd6, 4'd1, OP_OR);
    press(4'd4);
    check("arst_in_load_b", int'(state_o), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", int'(state_o), 0);
    check("arst_alu_a", int'(bus.alu_a), 0);
    check("arst_result", int'(result_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd12, 4'd7, OP_AND);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // A 2-cycle glitch never passes the debounce window
    @(negedge clk);
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("db_glitch", int'(state_o), 0);
    // A 10-cycle press advances once, 2+4 cycles after first sampling
    @(negedge clk);
    sw = 4'd3;
    btn_next = 1'b1;
    repeat (6) @(negedge clk);
    check("db_before", int'(state_o), 0);
    @(negedge clk);
    check("db_after", int'(state_o), 1);
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (GAP + 4) @(negedge clk);
    check("db_once", int'(state_o), 1);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
